// File: rtl/uart_mem_bridge_pkg.sv
// Shared types and constants for the UART memory bridge.
// Macro UART_BRIDGE_CHECKSUM_EN adds one XOR checksum byte to each direction.
package uart_mem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RECV = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int OP_WRITE_BIT = 0;
  localparam int OP_MASK_LSB  = 4;

  localparam int WDATA_LEN = 4;
  localparam int RESP_LEN  = 4;
  localparam int CSUM_LEN  = 1;
  localparam int IDX_W     = 4;

`ifdef UART_BRIDGE_CHECKSUM_EN
  localparam int CSUM_EXTRA = CSUM_LEN;
`else
  localparam int CSUM_EXTRA = 0;
`endif

  function automatic int base_len(input int addr_bytes);
    return 1 + addr_bytes;
  endfunction

  function automatic logic [7:0] opcode(input logic write, input logic [3:0] mask);
    logic [7:0] op;
    op                   = '0;
    op[OP_WRITE_BIT]     = write;
    op[OP_MASK_LSB +: 4] = mask;
    return op;
  endfunction

endpackage

// File: rtl/uart_mem_bridge_if.sv
// Request/response and UART byte-FIFO signals of the bridge.
// slave = bridge side, master = memory controller / transceiver side.
interface uart_mem_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_mask;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        send_flag;
  logic [7:0]  send_data;
  logic        sendable;
  logic        recv_flag;
  logic [7:0]  recv_data;
  logic        receivable;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_mask,
    input  sendable, recv_data, receivable,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output send_flag, send_data, recv_flag
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_mask,
    output sendable, recv_data, receivable,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  send_flag, send_data, recv_flag
  );
endinterface

// File: rtl/uart_mem_bridge_pkt_mux.sv
// Combinational packet byte selector: index -> opcode/address/wdata/checksum byte.
// Macro UART_BRIDGE_CHECKSUM_EN appends the XOR of all preceding bytes.
module uart_pkt_mux
  import uart_mem_bridge_pkg::*;
#(
  parameter int ADDR_BYTES = 4
) (
  input  logic [IDX_W-1:0] idx_i,
  input  logic             write_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       mask_i,
  output logic [7:0]       byte_o
);

  localparam int BASE_LEN = base_len(ADDR_BYTES);

  logic [7:0] pb [16];
`ifdef UART_BRIDGE_CHECKSUM_EN
  logic [7:0] csum;
`endif

  always_comb begin
    for (int i = 0; i < 16; i++) pb[i] = '0;
    pb[0] = opcode(write_i, mask_i);
    for (int i = 0; i < ADDR_BYTES; i++) pb[1 + i] = addr_i[8*i +: 8];
    if (write_i) begin
      for (int i = 0; i < WDATA_LEN; i++) pb[BASE_LEN + i] = wdata_i[8*i +: 8];
    end
`ifdef UART_BRIDGE_CHECKSUM_EN
    // unused slots are zero, so folding the whole array gives the packet XOR
    csum = '0;
    for (int i = 0; i < 16; i++) csum = csum ^ pb[i];
    if (write_i) pb[BASE_LEN + WDATA_LEN] = csum;
    else         pb[BASE_LEN] = csum;
`endif
    byte_o = pb[idx_i];
  end

endmodule

// File: rtl/uart_mem_bridge.sv
// Frames a 32-bit memory request into UART bytes and assembles read responses.
// Macro UART_BRIDGE_CHECKSUM_EN enables XOR checksum bytes on send and receive.
module uart_mem_bridge
  import uart_mem_bridge_pkg::*;
#(
  parameter int ADDR_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 0
) (
  input logic              CLK,
  input logic              RST,
  uart_mem_bridge_if.slave bus
);

  localparam int              BASE_LEN = base_len(ADDR_BYTES);
  localparam logic [IDX_W-1:0] WR_LAST = IDX_W'(BASE_LEN + WDATA_LEN + CSUM_EXTRA - 1);
  localparam logic [IDX_W-1:0] RD_LAST = IDX_W'(BASE_LEN + CSUM_EXTRA - 1);
  localparam logic [IDX_W-1:0] RX_LAST = IDX_W'(RESP_LEN + CSUM_EXTRA - 1);
  localparam logic [31:0]      TO_LIMIT = 32'(TIMEOUT_CYCLES);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             gap_q;
  logic             write_q;
  logic [31:0]      addr_q, wdata_q, rdata_q, to_q;
  logic [3:0]       mask_q;
  logic             req_ready_q, resp_valid_q, resp_err_q, send_flag_q, recv_flag_q;
  logic [31:0]      resp_rdata_q;
  logic [7:0]       send_data_q;
  logic [7:0]       pkt_byte;
  logic             timeout_hit;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_q == TO_LIMIT);

`ifdef UART_BRIDGE_CHECKSUM_EN
  logic csum_ok;
  assign csum_ok = bus.recv_data == (rdata_q[31:24] ^ rdata_q[23:16] ^ rdata_q[15:8] ^ rdata_q[7:0]);
`else
  logic [31:0] rx_word;
  assign rx_word = {bus.recv_data, rdata_q[23:0]};
`endif

  uart_pkt_mux #(.ADDR_BYTES(ADDR_BYTES)) u_pkt_mux (
    .idx_i   (idx_q),
    .write_i (write_q),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .mask_i  (mask_q),
    .byte_o  (pkt_byte)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      gap_q        <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      rdata_q      <= '0;
      to_q         <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      send_flag_q  <= 1'b0;
      send_data_q  <= '0;
      recv_flag_q  <= 1'b0;
    end else begin
      send_flag_q  <= 1'b0;
      recv_flag_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            write_q     <= bus.req_write;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            mask_q      <= bus.req_mask;
            idx_q       <= '0;
            gap_q       <= 1'b0;
            req_ready_q <= 1'b0;
            state_q     <= ST_SEND;
          end
        end
        ST_SEND: begin
          // the gap cycle gives the transceiver time to update sendable
          if (gap_q) begin
            gap_q <= 1'b0;
          end else if (bus.sendable) begin
            send_flag_q <= 1'b1;
            send_data_q <= pkt_byte;
            gap_q       <= 1'b1;
            idx_q       <= idx_q + 1'b1;
            if (idx_q == (write_q ? WR_LAST : RD_LAST)) begin
              if (write_q) begin
                state_q      <= ST_DONE;
                resp_valid_q <= 1'b1;
                resp_rdata_q <= '0;
                resp_err_q   <= 1'b0;
              end else begin
                state_q <= ST_RECV;
                idx_q   <= '0;
                to_q    <= '0;
              end
            end
          end
        end
        ST_RECV: begin
          if (timeout_hit) begin
            state_q      <= ST_DONE;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b1;
          end else if (!gap_q && bus.receivable) begin
            recv_flag_q <= 1'b1;
            gap_q       <= 1'b1;
            to_q        <= '0;
            idx_q       <= idx_q + 1'b1;
            if (idx_q < IDX_W'(RESP_LEN)) rdata_q[{idx_q[1:0], 3'b000} +: 8] <= bus.recv_data;
            if (idx_q == RX_LAST) begin
              state_q      <= ST_DONE;
              resp_valid_q <= 1'b1;
`ifdef UART_BRIDGE_CHECKSUM_EN
              resp_rdata_q <= csum_ok ? rdata_q : '0;
              resp_err_q   <= !csum_ok;
`else
              resp_rdata_q <= rx_word;
              resp_err_q   <= 1'b0;
`endif
            end
          end else begin
            gap_q <= 1'b0;
            to_q  <= to_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.send_flag  = send_flag_q;
  assign bus.send_data  = send_data_q;
  assign bus.recv_flag  = recv_flag_q;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed self-checking bench for uart_mem_bridge with simple send/receive FIFO models.
// Checksum cases are included when UART_BRIDGE_CHECKSUM_EN is defined.
module tb_uart_mem_bridge;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  uart_mem_bridge_if bus ();

  uart_mem_bridge #(.ADDR_BYTES(4), .TIMEOUT_CYCLES(100)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pops = 0;
  int overlap = 0;
  logic [7:0] sent[$];
  int         sent_cyc[$];
  int         pop_cyc[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_b[$];

  always @(posedge CLK) cyc <= cyc + 1;

  // FIFO models: record pushes, pop the receive head, refresh head outputs
  always @(negedge CLK) begin
    if (bus.send_flag === 1'b1) begin
      sent.push_back(bus.send_data);
      sent_cyc.push_back(cyc);
    end
    if (bus.recv_flag === 1'b1) begin
      pops++;
      pop_cyc.push_back(cyc);
      if (rx_q.size() != 0) void'(rx_q.pop_front());
    end
    if (bus.send_flag === 1'b1 && bus.recv_flag === 1'b1) overlap++;
    bus.receivable = (rx_q.size() != 0);
    bus.recv_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic clear_logs();
    sent.delete();
    sent_cyc.delete();
    pop_cyc.delete();
    pops = 0;
  endtask

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    int n = 0;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_mask  = m;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("req_ready_wait", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_sent(input int n, input int max);
    int i = 0;
    while (sent.size() < n && i < max) begin
      tick();
      i++;
    end
    check("wait_sent", 32'(sent.size() >= n), 32'd1);
  endtask

  task automatic wait_resp(input string tag, input logic [31:0] exp_rdata, input logic exp_err, input int max);
    int i = 0;
    while (bus.resp_valid !== 1'b1 && i < max) begin
      tick();
      i++;
    end
    check({tag, "_resp_seen"}, 32'(bus.resp_valid), 32'd1);
    if (bus.resp_valid === 1'b1) begin
      check({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
      check({tag, "_err"}, 32'(bus.resp_err), 32'(exp_err));
      tick();
      check({tag, "_pulse_once"}, 32'(bus.resp_valid), 32'd0);
      check({tag, "_ready_after"}, 32'(bus.req_ready), 32'd1);
    end
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] exp[$], input logic exact);
    int bad = 0;
    check({tag, "_count"}, 32'(sent.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s_byte%0d", tag, i),
            (i < sent.size()) ? 32'(sent[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
    for (int i = 1; i < sent_cyc.size(); i++) begin
      if (exact && (sent_cyc[i] - sent_cyc[i-1] != 2)) bad++;
      if (!exact && (sent_cyc[i] - sent_cyc[i-1] < 2)) bad++;
    end
    check({tag, "_spacing"}, 32'(bad), 32'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_mask  = '0;
    bus.sendable  = 1'b1;

    RST = 1'b1;
    repeat (3) tick();
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_send_flag", 32'(bus.send_flag), 32'd0);
    check("rst_send_data", 32'(bus.send_data), 32'd0);
    check("rst_recv_flag", 32'(bus.recv_flag), 32'd0);
    RST = 1'b0;
    tick();

    // full-mask write, back-to-back pushes every 2 cycles
    clear_logs();
    do_req(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF);
    wait_resp("wr", 32'h0, 1'b0, 100);
    exp_b = '{8'hF1, 8'h04, 8'h10, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef UART_BRIDGE_CHECKSUM_EN
    exp_b.push_back(8'hC7);
`endif
    check_bytes("wr", exp_b, 1'b1);
    check("wr_no_pops", 32'(pops), 32'd0);

    // response bytes sitting in the FIFO before the read must not be popped early
    clear_logs();
    rx_q.push_back(8'h78);
    rx_q.push_back(8'h56);
    rx_q.push_back(8'h34);
    rx_q.push_back(8'h12);
`ifdef UART_BRIDGE_CHECKSUM_EN
    rx_q.push_back(8'h08);
`endif
    repeat (10) tick();
    check("idle_no_pop", 32'(pops), 32'd0);
    do_req(1'b0, 32'h0000_0020, 32'h0, 4'hF);
    wait_resp("rd", 32'h1234_5678, 1'b0, 200);
    exp_b = '{8'hF0, 8'h20, 8'h00, 8'h00, 8'h00};
`ifdef UART_BRIDGE_CHECKSUM_EN
    exp_b.push_back(8'hD0);
    check("rd_pops", 32'(pops), 32'd5);
`else
    check("rd_pops", 32'(pops), 32'd4);
`endif
    check_bytes("rd", exp_b, 1'b1);

    // stall sendable after the third byte
    clear_logs();
    do_req(1'b1, 32'h1122_3344, 32'h5566_7788, 4'h3);
    wait_sent(3, 50);
    bus.sendable = 1'b0;
    repeat (50) tick();
    check("stall_no_push", 32'(sent.size()), 32'd3);
    check("stall_ready_low", 32'(bus.req_ready), 32'd0);
    bus.sendable = 1'b1;
    wait_resp("stall", 32'h0, 1'b0, 100);
    exp_b = '{8'h31, 8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
`ifdef UART_BRIDGE_CHECKSUM_EN
    exp_b.push_back(8'hB9);
`endif
    check_bytes("stall", exp_b, 1'b0);

    // timeout after two of the response bytes
    clear_logs();
    rx_q.push_back(8'h78);
    rx_q.push_back(8'h56);
    do_req(1'b0, 32'h0000_0040, 32'h0, 4'hF);
    wait_resp("to", 32'h0, 1'b1, 400);
    check("to_pops", 32'(pops), 32'd2);
    if (pop_cyc.size() == 2 && sent_cyc.size() != 0)
      check("to_delay_window",
            32'((cyc - 1 - pop_cyc[1]) >= 98 && (cyc - 1 - pop_cyc[1]) <= 104), 32'd1);
    else
      check("to_pop_log", 32'(pop_cyc.size()), 32'd2);
    exp_b = '{8'hF0, 8'h40, 8'h00, 8'h00, 8'h00};
`ifdef UART_BRIDGE_CHECKSUM_EN
    exp_b.push_back(8'hB0);
`endif
    check_bytes("to", exp_b, 1'b1);

    // reset in the middle of SEND
    clear_logs();
    do_req(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF);
    wait_sent(3, 50);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    check("mrst_req_ready", 32'(bus.req_ready), 32'd1);
    check("mrst_send_flag", 32'(bus.send_flag), 32'd0);
    check("mrst_send_data", 32'(bus.send_data), 32'd0);
    check("mrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("mrst_recv_flag", 32'(bus.recv_flag), 32'd0);
    repeat (10) tick();
    check("mrst_no_more_push", 32'(sent.size()), 32'd3);
    clear_logs();
    rx_q.push_back(8'h01);
    rx_q.push_back(8'h02);
    rx_q.push_back(8'h03);
    rx_q.push_back(8'h04);
`ifdef UART_BRIDGE_CHECKSUM_EN
    rx_q.push_back(8'h04);
`endif
    do_req(1'b0, 32'h0000_0020, 32'h0, 4'hF);
    wait_resp("fresh", 32'h0403_0201, 1'b0, 200);
    exp_b = '{8'hF0, 8'h20, 8'h00, 8'h00, 8'h00};
`ifdef UART_BRIDGE_CHECKSUM_EN
    exp_b.push_back(8'hD0);
`endif
    check_bytes("fresh", exp_b, 1'b1);

`ifdef UART_BRIDGE_CHECKSUM_EN
    // wrong then correct checksum on a read response
    clear_logs();
    rx_q.push_back(8'h78);
    rx_q.push_back(8'h56);
    rx_q.push_back(8'h34);
    rx_q.push_back(8'h12);
    rx_q.push_back(8'h00);
    do_req(1'b0, 32'h0000_0020, 32'h0, 4'hF);
    wait_resp("csum_bad", 32'h0, 1'b1, 200);
    check("csum_bad_pops", 32'(pops), 32'd5);
    clear_logs();
    rx_q.push_back(8'h78);
    rx_q.push_back(8'h56);
    rx_q.push_back(8'h34);
    rx_q.push_back(8'h12);
    rx_q.push_back(8'h08);
    do_req(1'b0, 32'h0000_0020, 32'h0, 4'hF);
    wait_resp("csum_good", 32'h1234_5678, 1'b0, 200);
`endif

    check("flag_overlap", 32'(overlap), 32'd0);
    check("rx_fifo_drained", 32'(rx_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_mem_bridge.md
Name: uart_mem_bridge

Overview:
Host-facing client of the UART byte-FIFO interface (send_flag/send_data/sendable, recv_flag/recv_data/receivable).
- Turns one 32-bit CPU memory request into a framed byte packet and pushes it into the transceiver's send FIFO.
- For reads, pops and assembles the 4-byte response from the receive FIFO.
- Sits between the memory controller and the UART transceiver.

Parameters:
ADDR_BYTES, 4, address bytes sent per packet (1..4; address LSBs first).
TIMEOUT_CYCLES, 0, cycles allowed between response bytes before abort; 0 disables the timeout.

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  bridge can accept a request
req_write  in  1  1=write, 0=read
req_addr  in  32  byte address
req_wdata  in  32  write data
req_mask  in  4  byte-enable mask
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  read data (0 for writes and aborts)
resp_err  out  1  valid with resp_valid: timeout or checksum error
send_flag  out  1  push send_data into UART send FIFO
send_data  out  8  byte to push
sendable  in  1  send FIFO not full
recv_flag  out  1  pop UART receive FIFO
recv_data  in  8  receive FIFO head byte (valid while receivable)
receivable  in  1  receive FIFO not empty

Behaviour:
- Outputs are registered.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, send_flag=0, send_data=0, recv_flag=0. State=IDLE, counters=0.
- Reset mid-operation abandons the packet. Bytes already pushed stay in the UART FIFO; no drain is performed.
- Packet bytes, in order:
  - Opcode {req_mask[3:0], 3'b000, req_write}.
  - ADDR_BYTES address bytes, little-endian.
  - Writes only: 4 wdata bytes, little-endian.
- States:
  - IDLE
    - req_ready=1.
    - On req_valid && req_ready: latch write/addr/wdata/mask, byte index=0, req_ready<=0, go SEND.
  - SEND
    - When the gap flag is clear and sendable=1: send_flag<=1, send_data<=byte[idx], idx++, set gap flag.
    - Gap flag forces send_flag=0 the next cycle, so at most one push per 2 cycles. This lets the FIFO full flag update.
    - sendable=0: stall indefinitely.
    - After the last byte is pushed: write -> DONE; read -> RECV with byte count=0.
  - RECV
    - When the gap flag is clear and receivable=1: recv_flag<=1.
    - Capture recv_data into rdata[8*k+:8] in the same cycle, k++. Same one-cycle gap rule as SEND.
    - After 4 bytes -> DONE.
    - Timeout counter clears on each pop and on entry. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES: go DONE with err=1 and rdata=0.
  - DONE
    - resp_valid=1 for exactly one cycle; resp_rdata/resp_err are driven.
    - Next cycle: IDLE, req_ready=1.
    - resp_rdata holds its value until the next DONE.
- Latency: the earliest new accept is the cycle after resp_valid. Minimum write packet (ADDR_BYTES=4) is 9 bytes = 18 cycles in SEND.
- Bytes arriving in the receive FIFO outside RECV are never popped.
- Writes: resp_rdata=0, resp_err=0.
- send_flag and recv_flag are never asserted in the same cycle.

Optional Feature:
- Macro UART_BRIDGE_CHECKSUM_EN.
- Defined:
  - SEND appends one extra byte: the XOR of all preceding packet bytes.
  - RECV expects 5 bytes: 4 data bytes plus an XOR checksum of those 4.
  - On mismatch: resp_err=1, resp_rdata=0.
  - Timeout rules unchanged.
- Undefined: no checksum bytes are sent or expected; resp_err is set only by timeout.

Decomposition:
- Shared package holds:
  - State encoding (IDLE/SEND/RECV/DONE).
  - Opcode field positions (write bit 0, mask bits 7:4).
  - Packet length constants: BASE_LEN=1+ADDR_BYTES, WDATA_LEN=4, RESP_LEN=4, CSUM_LEN=1.
- One natural sub-module, uart_pkt_mux: combinational byte selector mapping index -> packet byte (opcode/addr/wdata/checksum). Keeps the FSM free of byte muxing.

Test Plan:
- Write addr=0x00001004, wdata=0xDEADBEEF, mask=4'hF, sendable=1:
  - send_data sequence F1,04,10,00,00,EF,BE,AD,DE, one push every 2 cycles.
  - resp_valid pulses once with rdata=0.
- Read addr=0x20, mask=4'hF:
  - Bytes sent F0,20,00,00,00.
  - Then feed 78,56,34,12 via receivable/recv_data.
  - resp_rdata=0x12345678, resp_err=0, four recv_flag pulses.
- Hold sendable=0 for 50 cycles after the third byte: no send_flag during the stall; the remaining bytes follow in order once sendable=1.
- TIMEOUT_CYCLES=100, read with only 2 response bytes: resp_valid about 100 cycles after the 2nd pop, resp_err=1, rdata=0, req_ready=1 next cycle.
- Assert RST for one cycle mid-SEND (after 3 bytes): all outputs at reset values next cycle. A new read then sends a fresh opcode byte first.
- With UART_BRIDGE_CHECKSUM_EN, read response 78,56,34,12,00:
  - 00 is a wrong checksum (correct is 0x08), so resp_err=1, rdata=0.
  - Sending 08 instead gives resp_err=0, rdata=0x12345678.
